// File: rtl/pcm_pkg.sv
// Shared constants and helpers for the PCM TDOA collector slice.
// FSM state codes are plain localparams so legacy blocks can share them.
package pcm_pkg;

  localparam int TW_DEFAULT = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARMED   = 3'd1;
  localparam state_t ST_COLLECT = 3'd2;
  localparam state_t ST_COMPUTE = 3'd3;
  localparam state_t ST_REPORT  = 3'd4;
  localparam state_t ST_HOLDOFF = 3'd5;

  // Clamp a modular time difference to the largest value a dw-bit delta can hold.
  function automatic logic [63:0] sat_delta(input logic [63:0] diff, input int unsigned dw);
    logic [63:0] max_val;
    max_val = (64'd1 << dw) - 64'd1;
    return (diff > max_val) ? max_val : diff;
  endfunction

endpackage

// File: rtl/pcm_priority_encoder.sv
// Lowest-index-wins priority encoder used to pick the earliest detector channel.
module pcm_priority_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [2:0]   idx_o,
  output logic         any_o
);

  always_comb begin
    // NOTE: default assignment first so no path leaves idx_o unassigned (no latch).
    idx_o = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/pcm_tdoa_collector.sv
// Collects NUM_CH peak-detector triggers into one TDOA event with a valid/ack
// handshake, owns the shared sample counter and the detectors' common reset.
module pcm_tdoa_collector
  import pcm_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TW      = TW_DEFAULT,
  parameter int DW      = 16,
  parameter int TIMEOUT = 4800,
  parameter int HOLDOFF = 2400
) (
  input  logic                 pcm_clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic [NUM_CH-1:0]    triggered,
  input  logic [NUM_CH*TW-1:0] triggered_time,
  output logic [TW-1:0]        sample_counter,
  output logic                 det_reset,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [2:0]           first_ch,
  output logic [TW-1:0]        first_time,
  output logic [NUM_CH*DW-1:0] delta,
  output logic [NUM_CH-1:0]    missing
);

  localparam int TMAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int CW   = $clog2(TMAX + 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       timer_q, timer_d;
  logic                det_reset_q, det_reset_d;
  logic                valid_q, valid_d;
  logic [2:0]          first_ch_q, first_ch_d;
  logic [TW-1:0]       first_time_q, first_time_d;
  logic [NUM_CH*DW-1:0] delta_q, delta_d;
  logic [NUM_CH-1:0]   missing_q, missing_d;

  // Event data captured while collecting; published only at COMPUTE so the
  // reported outputs stay put until the next event is complete.
  logic [2:0]          ch_pend_q, ch_pend_d;
  logic [TW-1:0]       time_pend_q, time_pend_d;
  logic [NUM_CH-1:0]   miss_pend_q, miss_pend_d;

  logic [2:0]          pe_idx;
  logic                pe_any;
  logic [TW-1:0]       first_sel;
  logic [NUM_CH*DW-1:0] delta_calc;

  pcm_priority_encoder #(.N(NUM_CH)) u_first_pe (
    .req_i (triggered),
    .idx_o (pe_idx),
    .any_o (pe_any)
  );

  always_comb begin
    first_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pe_idx == 3'(i)) first_sel = triggered_time[i*TW +: TW];
    end
  end

  // Modular subtraction keeps deltas correct across the sample_counter wrap.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_delta
    logic [TW-1:0] diff;
    assign diff = triggered_time[g*TW +: TW] - time_pend_q;
    assign delta_calc[g*DW +: DW] = miss_pend_q[g] ? {DW{1'b1}}
                                                   : DW'(sat_delta(64'(diff), DW));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    timer_d      = timer_q;
    valid_d      = valid_q;
    first_ch_d   = first_ch_q;
    first_time_d = first_time_q;
    delta_d      = delta_q;
    missing_d    = missing_q;
    ch_pend_d    = ch_pend_q;
    time_pend_d  = time_pend_q;
    miss_pend_d  = miss_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (pe_any) begin
          ch_pend_d   = pe_idx;
          time_pend_d = first_sel;
          timer_d     = '0;
          state_d     = ST_COLLECT;
        end else if (!arm) begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        timer_d = timer_q + 1'b1;
        if (&triggered) begin
          miss_pend_d = '0;
          state_d     = ST_COMPUTE;
        end else if (timer_q == CW'(TIMEOUT - 1)) begin
          miss_pend_d = ~triggered;
          state_d     = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        first_ch_d   = ch_pend_q;
        first_time_d = time_pend_q;
        delta_d      = delta_calc;
        missing_d    = miss_pend_q;
        valid_d      = 1'b1;
        state_d      = ST_REPORT;
      end
      ST_REPORT: begin
        if (result_ack) begin
          valid_d = 1'b0;
          timer_d = '0;
          state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == CW'(HOLDOFF - 1)) state_d = arm ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Derived from the next state so det_reset leaves a flop, never from inputs.
    det_reset_d = (state_d == ST_IDLE) || (state_d == ST_HOLDOFF);
  end

  always_ff @(posedge pcm_clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      det_reset_q  <= 1'b1;
      valid_q      <= 1'b0;
      first_ch_q   <= '0;
      first_time_q <= '0;
      delta_q      <= '0;
      missing_q    <= '0;
      ch_pend_q    <= '0;
      time_pend_q  <= '0;
      miss_pend_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      det_reset_q  <= det_reset_d;
      valid_q      <= valid_d;
      first_ch_q   <= first_ch_d;
      first_time_q <= first_time_d;
      delta_q      <= delta_d;
      missing_q    <= missing_d;
      ch_pend_q    <= ch_pend_d;
      time_pend_q  <= time_pend_d;
      miss_pend_q  <= miss_pend_d;
    end
  end

  assign sample_counter = cnt_q;
  assign det_reset      = det_reset_q;
  assign result_valid   = valid_q;
  assign first_ch       = first_ch_q;
  assign first_time     = first_time_q;
  assign delta          = delta_q;
  assign missing        = missing_q;

endmodule

// File: tb/tb_pcm_tdoa_collector.sv
// Scoreboard bench for pcm_tdoa_collector: a stimulus process pushes expected
// events computed from trigger schedules, a monitor pops them as results appear.
module tb_pcm_tdoa_collector;

  localparam int NUM_CH  = 4;
  localparam int TW      = 32;
  localparam int DW      = 16;
  localparam int TIMEOUT = 4800;
  localparam int HOLDOFF = 2400;

  logic                 pcm_clk = 1'b0;
  logic                 reset;
  logic                 arm;
  logic [NUM_CH-1:0]    triggered;
  logic [NUM_CH*TW-1:0] triggered_time;
  logic [TW-1:0]        sample_counter;
  logic                 det_reset;
  logic                 result_valid;
  logic                 result_ack;
  logic [2:0]           first_ch;
  logic [TW-1:0]        first_time;
  logic [NUM_CH*DW-1:0] delta;
  logic [NUM_CH-1:0]    missing;

  pcm_tdoa_collector #(
    .NUM_CH(NUM_CH), .TW(TW), .DW(DW), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .pcm_clk        (pcm_clk),
    .reset          (reset),
    .arm            (arm),
    .triggered      (triggered),
    .triggered_time (triggered_time),
    .sample_counter (sample_counter),
    .det_reset      (det_reset),
    .result_valid   (result_valid),
    .result_ack     (result_ack),
    .first_ch       (first_ch),
    .first_time     (first_time),
    .delta          (delta),
    .missing        (missing)
  );

  always #5 pcm_clk = ~pcm_clk;

  typedef struct {
    logic [2:0]           first_ch;
    logic [TW-1:0]        first_time;
    logic [NUM_CH*DW-1:0] delta;
    logic [NUM_CH-1:0]    missing;
    int                   cyc;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [TW-1:0] cnt_exp  = '0;

  // Event description: per-channel time value and trigger offset in cycles
  // after the first trigger (-1 = never triggers).
  logic [TW-1:0] ev_time[NUM_CH];
  int            ev_off[NUM_CH];
  int            stray_k = -1;

  always @(posedge pcm_clk) begin
    cyc     <= cyc + 1;
    cnt_exp <= reset ? '0 : cnt_exp + 1'b1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who is first, what every channel reports, and when.
  function automatic exp_t model_event(input int f);
    exp_t          e;
    int            first = -1;
    int            last  = 0;
    bit            all_in = 1'b1;
    logic [TW-1:0] d;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ev_off[i] >= 0 && ev_off[i] <= TIMEOUT) begin
        if (first < 0 || ev_off[i] < ev_off[first]) first = i;
        if (ev_off[i] > last) last = ev_off[i];
      end else begin
        all_in = 1'b0;
      end
    end
    e.first_ch   = 3'(first);
    e.first_time = ev_time[first];
    for (int i = 0; i < NUM_CH; i++) begin
      e.missing[i] = !(ev_off[i] >= 0 && ev_off[i] <= TIMEOUT);
      d = ev_time[i] - e.first_time;
      if (e.missing[i] || d > TW'((1 << DW) - 1)) e.delta[i*DW +: DW] = '1;
      else                                          e.delta[i*DW +: DW] = d[DW-1:0];
    end
    e.cyc = all_in ? f + ((last < 1) ? 1 : last) + 2 : f + TIMEOUT + 2;
    return e;
  endfunction

  task automatic apply(input int k);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ev_off[i] == k) triggered[i] = 1'b1;
    end
  endtask

  task automatic wait_armed();
    int n = 0;
    while (det_reset && n < HOLDOFF + 100) begin
      @(negedge pcm_clk);
      n++;
    end
    check("armed_reached", det_reset, 1'b0);
    check("sample_counter", sample_counter, cnt_exp);
  endtask

  task automatic run_event(input int hold, input bit reset_instead);
    bit seen = 1'b0;
    int n    = 0;
    wait_armed();
    sb_q.push_back(model_event(cyc));
    for (int i = 0; i < NUM_CH; i++) triggered_time[i*TW +: TW] = ev_time[i];
    apply(0);
    for (int k = 1; k <= TIMEOUT + 60 && !seen; k++) begin
      @(negedge pcm_clk);
      result_ack = (k == stray_k);
      if (result_valid) seen = 1'b1;
      else              apply(k);
    end
    result_ack = 1'b0;
    stray_k    = -1;
    check("result_valid_seen", seen, 1'b1);
    if (reset_instead) begin
      reset = 1'b1;
      @(negedge pcm_clk);
      check("rst_valid", result_valid, 1'b0);
      check("rst_det_reset", det_reset, 1'b1);
      check("rst_sample_counter", sample_counter, '0);
      reset     = 1'b0;
      triggered = '0;
    end else begin
      repeat (hold) @(negedge pcm_clk);
      result_ack = 1'b1;
      @(negedge pcm_clk);
      result_ack = 1'b0;
      triggered  = '0;
      check("ack_valid_drop", result_valid, 1'b0);
      while (det_reset && n < HOLDOFF + 100) begin
        n++;
        @(negedge pcm_clk);
      end
      check("holdoff_len", n, HOLDOFF);
    end
  endtask

  // Monitor: pops one expectation per rising result_valid, then checks hold stability.
  initial begin
    exp_t cur;
    bit   have_cur   = 1'b0;
    logic valid_prev = 1'b0;
    forever begin
      @(negedge pcm_clk);
      if (result_valid && !valid_prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got result with empty scoreboard (cycle %0d)", cyc);
          have_cur = 1'b0;
        end else begin
          cur      = sb_q.pop_front();
          have_cur = 1'b1;
          check("valid_cycle", cyc, cur.cyc);
          check("first_ch", first_ch, cur.first_ch);
          check("first_time", first_time, cur.first_time);
          check("delta", delta, cur.delta);
          check("missing", missing, cur.missing);
        end
      end else if (result_valid && have_cur) begin
        check("hold_stable", {first_ch, first_time, delta, missing},
              {cur.first_ch, cur.first_time, cur.delta, cur.missing});
      end
      valid_prev = result_valid;
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1);
  end

  task automatic set_ev(input logic [TW-1:0] t0, t1, t2, t3, input int o0, o1, o2, o3);
    ev_time[0] = t0; ev_time[1] = t1; ev_time[2] = t2; ev_time[3] = t3;
    ev_off[0]  = o0; ev_off[1]  = o1; ev_off[2]  = o2; ev_off[3]  = o3;
  endtask

  initial begin
    logic [TW-1:0] base;
    int            mode;
    int            min_off;
    reset = 1'b1; arm = 1'b0; triggered = '0; triggered_time = '0; result_ack = 1'b0;
    repeat (3) @(negedge pcm_clk);
    check("reset_det_reset", det_reset, 1'b1);
    check("reset_valid", result_valid, 1'b0);
    check("reset_counter", sample_counter, '0);
    check("reset_results", {first_ch, first_time, delta, missing}, '0);
    reset = 1'b0;
    arm   = 1'b1;
    @(negedge pcm_clk);

    wait_armed();
    arm = 1'b0;
    @(negedge pcm_clk);
    check("disarm_to_idle", det_reset, 1'b1);
    arm = 1'b1;

    // Basic event with a stray ack while no result is pending.
    set_ev(32'd100, 32'd103, 32'd110, 32'd105, 0, 3, 10, 5);
    stray_k = 2;
    run_event(3, 1'b0);
    // Tie between ch1 and ch2.
    set_ev(32'd507, 32'd500, 32'd500, 32'd502, 7, 0, 0, 2);
    run_event(50, 1'b0);
    // ch3 never arrives.
    set_ev(32'd1000, 32'd1001, 32'd1002, 32'd0, 0, 1, 2, -1);
    run_event(1, 1'b0);
    // Last arrival on the very timeout cycle still counts as present.
    set_ev(32'd2000, 32'd2001, 32'd6800, 32'd2002, 0, 1, TIMEOUT, 2);
    run_event(0, 1'b0);
    // One cycle late is missing.
    set_ev(32'd9000, 32'd8000, 32'd8001, 32'd8002, TIMEOUT + 1, 0, 1, 2);
    run_event(2, 1'b0);
    // Straddles the counter wrap.
    set_ev(32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 0, 5, 1, 2);
    run_event(4, 1'b0);
    // Saturation edge: 65535 fits, 65536 and beyond clamp.
    set_ev(32'd0, 32'd70000, 32'd65535, 32'd65536, 0, 1, 2, 3);
    run_event(1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      base = $urandom;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < NUM_CH; i++) ev_off[i] = $urandom_range(0, 30);
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < NUM_CH; i++) ev_off[i] = 0;
      end
      min_off = ev_off[0];
      for (int i = 1; i < NUM_CH; i++) if (ev_off[i] < min_off) min_off = ev_off[i];
      for (int i = 0; i < NUM_CH; i++) begin
        ev_off[i] -= min_off;
        case (mode)
          0:       ev_time[i] = base + TW'(ev_off[i]);
          1:       ev_time[i] = base + TW'(ev_off[i] * $urandom_range(0, 6000));
          default: ev_time[i] = $urandom;
        endcase
      end
      run_event($urandom_range(0, 10), 1'b0);
    end

    // Reset while an event is being reported.
    set_ev(32'd300, 32'd301, 32'd302, 32'd303, 0, 1, 2, 3);
    run_event(0, 1'b1);
    wait_armed();

    repeat (5) @(negedge pcm_clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
